hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 143 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard detection and EX-stage forwarding select generation.
// Tracks destination tags of in-flight instructions, derives the ID stall (load-use,
// HI/LO busy, MDU structural) and registers forwarding selects so they line up with EX.
module hazard_scoreboard #(
  parameter int REG_W   = 6,
  parameter int MDU_LAT = 4,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IdValid,
  input  logic [REG_W-1:0] IdReadReg1,
  input  logic [REG_W-1:0] IdReadReg2,
  input  logic [REG_W-1:0] IdWriteReg,
  input  logic             IdIsLoad,
  input  logic             IdIsMdu,
  input  logic             ExFlush,
  output logic             Stall,
  output logic [1:0]       FwdSel1,
  output logic [1:0]       FwdSel2,
  output logic             MduBusy
);

  localparam logic [REG_W-1:0] HILO_TAG = REG_W'(33);
  localparam logic [3:0]       MDU_LOAD = 4'(MDU_LAT);

  // Only EX and MEM occupancy influence any output: the regfile writes through from WB,
  // and MEM's load flag never matters because a load in MEM is always forwardable.
  logic             ex_v_q,    ex_v_d;
  logic [REG_W-1:0] ex_wreg_q, ex_wreg_d;
  logic             ex_ld_q,   ex_ld_d;
  logic             mem_v_q,   mem_v_d;
  logic [REG_W-1:0] mem_wreg_q, mem_wreg_d;
  logic [3:0]       mdu_cnt_q, mdu_cnt_d;
  logic [1:0]       fwd1_q,    fwd1_d;
  logic [1:0]       fwd2_q,    fwd2_d;

  logic hazard;
  logic issue;
  logic mdu_busy;

  // A producer slot matches a source tag; tag 0 is never a dependency.
  function automatic logic match(input logic [REG_W-1:0] r,
                                 input logic             v,
                                 input logic [REG_W-1:0] w);
    return v && (w == r) && (r != '0);
  endfunction

  // Forward source for one operand, youngest producer first; HI/LO is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] r,
                                         input logic             exv,
                                         input logic [REG_W-1:0] exw,
                                         input logic             exld,
                                         input logic             memv,
                                         input logic [REG_W-1:0] memw);
    if (match(r, exv, exw) && !exld && (r != HILO_TAG)) begin
      return 2'b01;
    end else if (match(r, memv, memw) && (r != HILO_TAG)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  // Combinational hazard detection for the instruction currently in ID.
  always_comb begin
    logic m1_ex, m2_ex, m1_mem, m2_mem;
    logic hilo_rd;
    m1_ex   = match(IdReadReg1, ex_v_q, ex_wreg_q);
    m2_ex   = match(IdReadReg2, ex_v_q, ex_wreg_q);
    m1_mem  = match(IdReadReg1, mem_v_q, mem_wreg_q);
    m2_mem  = match(IdReadReg2, mem_v_q, mem_wreg_q);
    hilo_rd = (IdReadReg1 == HILO_TAG) || (IdReadReg2 == HILO_TAG);
    mdu_busy = (mdu_cnt_q != 4'd0);
    hazard = 1'b0;
    if (ex_ld_q && (m1_ex || m2_ex)) begin
      hazard = 1'b1;
    end
    if (!FWD_EN && (m1_ex || m2_ex || m1_mem || m2_mem)) begin
      hazard = 1'b1;
    end
    if (mdu_busy && (hilo_rd || IdIsMdu)) begin
      hazard = 1'b1;
    end
    hazard = hazard && IdValid;
    Stall  = hazard && !ExFlush;
    issue  = IdValid && !Stall && !ExFlush;
  end

  // Next-state: slots shift every cycle, ID issues or a bubble enters EX.
  always_comb begin
    mem_v_d    = ex_v_q;
    mem_wreg_d = ex_wreg_q;
    ex_v_d     = 1'b0;
    ex_wreg_d  = '0;
    ex_ld_d    = 1'b0;
    fwd1_d     = 2'b00;
    fwd2_d     = 2'b00;
    if (issue) begin
      ex_v_d    = 1'b1;
      ex_wreg_d = IdWriteReg;
      ex_ld_d   = IdIsLoad;
      if (FWD_EN) begin
        fwd1_d = fwd_sel(IdReadReg1, ex_v_q, ex_wreg_q, ex_ld_q, mem_v_q, mem_wreg_q);
        fwd2_d = fwd_sel(IdReadReg2, ex_v_q, ex_wreg_q, ex_ld_q, mem_v_q, mem_wreg_q);
      end
    end
    if (issue && IdIsMdu) begin
      mdu_cnt_d = MDU_LOAD;
    end else if (mdu_cnt_q != 4'd0) begin
      mdu_cnt_d = mdu_cnt_q - 4'd1;
    end else begin
      mdu_cnt_d = 4'd0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_q     <= 1'b0;
      ex_wreg_q  <= '0;
      ex_ld_q    <= 1'b0;
      mem_v_q    <= 1'b0;
      mem_wreg_q <= '0;
      mdu_cnt_q  <= 4'd0;
      fwd1_q     <= 2'b00;
      fwd2_q     <= 2'b00;
    end else begin
      ex_v_q     <= ex_v_d;
      ex_wreg_q  <= ex_wreg_d;
      ex_ld_q    <= ex_ld_d;
      mem_v_q    <= mem_v_d;
      mem_wreg_q <= mem_wreg_d;
      mdu_cnt_q  <= mdu_cnt_d;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
    end
  end

  assign FwdSel1 = fwd1_q;
  assign FwdSel2 = fwd2_q;
  assign MduBusy = mdu_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: two scoreboards (forwarding on / off) driven by directed and
// random ID streams, checked against a cycle-indexed issue log model.
module tb_hazard_scoreboard;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv[2];
  logic [5:0] ir1[2], ir2[2], iw[2];
  logic       ild[2], imdu[2], ifl[2];
  logic       st[2], mb[2];
  logic [1:0] f1[2], f2[2];

  hazard_scoreboard #(.REG_W(6), .MDU_LAT(LAT), .FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .IdValid(iv[0]), .IdReadReg1(ir1[0]), .IdReadReg2(ir2[0]),
    .IdWriteReg(iw[0]), .IdIsLoad(ild[0]), .IdIsMdu(imdu[0]), .ExFlush(ifl[0]),
    .Stall(st[0]), .FwdSel1(f1[0]), .FwdSel2(f2[0]), .MduBusy(mb[0]));

  hazard_scoreboard #(.REG_W(6), .MDU_LAT(LAT), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst(rst), .IdValid(iv[1]), .IdReadReg1(ir1[1]), .IdReadReg2(ir2[1]),
    .IdWriteReg(iw[1]), .IdIsLoad(ild[1]), .IdIsMdu(imdu[1]), .ExFlush(ifl[1]),
    .Stall(st[1]), .FwdSel1(f1[1]), .FwdSel2(f2[1]), .MduBusy(mb[1]));

  // Issue log: entry for cycle t records what left ID at the end of cycle t.
  // At cycle t the EX occupant is log[t-1], the MEM occupant is log[t-2].
  typedef struct packed {
    logic       v;
    logic [5:0] w;
    logic       ld;
    logic [1:0] s1;
    logic [1:0] s2;
  } rec_t;

  rec_t log_q[2][16];
  int   cyc = 0;
  int   free_c[2];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m(input logic [5:0] r, input rec_t s);
    return s.v && (s.w == r) && (r != 6'd0);
  endfunction

  function automatic rec_t ex_of(input int i);
    return log_q[i][(cyc - 1) & 15];
  endfunction

  function automatic rec_t mem_of(input int i);
    return log_q[i][(cyc - 2) & 15];
  endfunction

  function automatic bit busy_of(input int i);
    return cyc < free_c[i];
  endfunction

  // Instance 0 forwards, instance 1 does not.
  function automatic bit exp_stall(input int i);
    rec_t ex, mem;
    bit h;
    ex  = ex_of(i);
    mem = mem_of(i);
    h = ex.ld && (m(ir1[i], ex) || m(ir2[i], ex));
    if (i == 1)
      h = h || m(ir1[i], ex) || m(ir2[i], ex) || m(ir1[i], mem) || m(ir2[i], mem);
    h = h || (busy_of(i) && (ir1[i] == 6'd33 || ir2[i] == 6'd33 || imdu[i]));
    return iv[i] && h && !ifl[i];
  endfunction

  function automatic logic [1:0] exp_sel(input int i, input logic [5:0] r);
    rec_t ex, mem;
    ex  = ex_of(i);
    mem = mem_of(i);
    if (i == 1) return 2'b00;
    if (m(r, ex) && !ex.ld && r != 6'd33) return 2'b01;
    if (m(r, mem) && r != 6'd33) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_update();
    rec_t n[2];
    for (int i = 0; i < 2; i++) begin
      n[i] = '0;
      if (iv[i] && !exp_stall(i) && !ifl[i]) begin
        n[i].v  = 1'b1;
        n[i].w  = iw[i];
        n[i].ld = ild[i];
        n[i].s1 = exp_sel(i, ir1[i]);
        n[i].s2 = exp_sel(i, ir2[i]);
        if (imdu[i]) free_c[i] = cyc + 1 + LAT;
      end
    end
    for (int i = 0; i < 2; i++) log_q[i][cyc & 15] = n[i];
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) log_q[i][k] = '0;
      free_c[i] = 0;
    end
  endtask

  // Every-cycle comparison of both scoreboards against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < 2; i++) begin
        rec_t ex;
        ex = ex_of(i);
        check($sformatf("stall%0d", i), {7'd0, st[i]}, {7'd0, exp_stall(i)});
        check($sformatf("fwd1_%0d", i), {6'd0, f1[i]}, {6'd0, ex.s1});
        check($sformatf("fwd2_%0d", i), {6'd0, f2[i]}, {6'd0, ex.s2});
        check($sformatf("busy%0d", i), {7'd0, mb[i]}, {7'd0, busy_of(i)});
      end
    end
  end

  task automatic drv(input int i, input bit v, input logic [5:0] r1, input logic [5:0] r2,
                     input logic [5:0] w, input bit ld, input bit mdu, input bit fl);
    iv[i] = v; ir1[i] = r1; ir2[i] = r2; iw[i] = w; ild[i] = ld; imdu[i] = mdu; ifl[i] = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_n(input int n);
    repeat (n) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  function automatic logic [5:0] rtag();
    case ($urandom_range(0, 5))
      0: return 6'd0;
      1: return 6'd1;
      2: return 6'd2;
      3: return 6'd3;
      4: return 6'd33;
      default: return 6'd5;
    endcase
  endfunction

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check("rst_stall", {7'd0, st[0]}, 8'd0);
    check("rst_busy", {7'd0, mb[0]}, 8'd0);
    check("rst_fwd1", {6'd0, f1[0]}, 8'd0);
    check("rst_fwd2", {6'd0, f2[1]}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle_n(2);

    // Load-use: one stall cycle, then MEM/WB forward.
    drv(0, 1, 6'd1, 6'd0, 6'd8, 1, 0, 0);
    #2 check("t1_lw_nostall", {7'd0, st[0]}, 8'd0);
    tick();
    drv(0, 1, 6'd8, 6'd10, 6'd9, 0, 0, 0);
    #2 check("t1_stall", {7'd0, st[0]}, 8'd1);
    tick();
    #2 check("t1_release", {7'd0, st[0]}, 8'd0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("t1_fwd1", {6'd0, f1[0]}, 8'd2);
    check("t1_fwd2", {6'd0, f2[0]}, 8'd0);
    tick();
    idle_n(3);

    // ALU producer: EX/MEM forward on operand 2, no stall.
    drv(0, 1, 6'd1, 6'd2, 6'd8, 0, 0, 0);
    tick();
    drv(0, 1, 6'd12, 6'd8, 6'd11, 0, 0, 0);
    #2 check("t2_stall", {7'd0, st[0]}, 8'd0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("t2_fwd2", {6'd0, f2[0]}, 8'd1);
    check("t2_fwd1", {6'd0, f1[0]}, 8'd0);
    tick();
    idle_n(3);

    // Youngest producer wins; then the same with $0.
    drv(0, 1, 6'd1, 6'd2, 6'd8, 0, 0, 0);
    tick();
    drv(0, 1, 6'd1, 6'd2, 6'd8, 0, 0, 0);
    tick();
    drv(0, 1, 6'd8, 6'd8, 6'd3, 0, 0, 0);
    #2 check("t3_stall", {7'd0, st[0]}, 8'd0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("t3_fwd1", {6'd0, f1[0]}, 8'd1);
    check("t3_fwd2", {6'd0, f2[0]}, 8'd1);
    tick();
    drv(0, 1, 6'd1, 6'd2, 6'd0, 0, 0, 0);
    tick();
    drv(0, 1, 6'd1, 6'd2, 6'd0, 1, 0, 0);
    tick();
    drv(0, 1, 6'd0, 6'd0, 6'd3, 0, 0, 0);
    #2 check("t3z_stall", {7'd0, st[0]}, 8'd0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("t3z_fwd1", {6'd0, f1[0]}, 8'd0);
    check("t3z_fwd2", {6'd0, f2[0]}, 8'd0);
    tick();
    idle_n(3);

    // MULTU then MFLO: four stall cycles, then plain regfile read.
    drv(0, 1, 6'd4, 6'd5, 6'd33, 0, 1, 0);
    #2 check("t4_multu", {7'd0, st[0]}, 8'd0);
    tick();
    drv(0, 1, 6'd33, 6'd0, 6'd2, 0, 0, 0);
    for (int k = 0; k < LAT; k++) begin
      #2 check($sformatf("t4_stall%0d", k), {7'd0, st[0]}, 8'd1);
      check($sformatf("t4_busy%0d", k), {7'd0, mb[0]}, 8'd1);
      tick();
    end
    #2 check("t4_release", {7'd0, st[0]}, 8'd0);
    check("t4_notbusy", {7'd0, mb[0]}, 8'd0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("t4_fwd1", {6'd0, f1[0]}, 8'd0);
    tick();
    drv(0, 1, 6'd4, 6'd5, 6'd33, 0, 1, 0);
    tick();
    #2 check("t4_struct", {7'd0, st[0]}, 8'd1);
    tick();
    idle_n(6);

    // Load-use squashed by a flush: no stall, bubble in EX.
    drv(0, 1, 6'd1, 6'd0, 6'd8, 1, 0, 0);
    tick();
    drv(0, 1, 6'd8, 6'd0, 6'd9, 0, 0, 1);
    #2 check("t5_stall", {7'd0, st[0]}, 8'd0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("t5_fwd1", {6'd0, f1[0]}, 8'd0);
    check("t5_fwd2", {6'd0, f2[0]}, 8'd0);
    tick();
    idle_n(3);

    // Async reset mid-count with all slots busy.
    drv(0, 1, 6'd1, 6'd2, 6'd7, 0, 0, 0);
    tick();
    drv(0, 1, 6'd4, 6'd5, 6'd33, 0, 1, 0);
    tick();
    drv(0, 1, 6'd7, 6'd0, 6'd9, 0, 0, 0);
    #2 check("t6_pre_nostall", {7'd0, st[0]}, 8'd0);
    tick();
    drv(0, 1, 6'd33, 6'd9, 6'd2, 0, 0, 0);
    #2 check("t6_busy", {7'd0, mb[0]}, 8'd1);
    check("t6_stall", {7'd0, st[0]}, 8'd1);
    check("t6_fwd1", {6'd0, f1[0]}, 8'd2);
    rst = 1'b1;
    #1 check("t6_rst_busy", {7'd0, mb[0]}, 8'd0);
    check("t6_rst_stall", {7'd0, st[0]}, 8'd0);
    check("t6_rst_fwd1", {6'd0, f1[0]}, 8'd0);
    check("t6_rst_fwd2", {6'd0, f2[0]}, 8'd0);
    model_reset();
    #3 rst = 1'b0;
    tick();
    idle_n(3);

    // No-forwarding build: dependent add stalls two cycles.
    drv(1, 1, 6'd1, 6'd2, 6'd8, 0, 0, 0);
    #2 check("nf_first", {7'd0, st[1]}, 8'd0);
    tick();
    drv(1, 1, 6'd8, 6'd0, 6'd9, 0, 0, 0);
    #2 check("nf_stall_ex", {7'd0, st[1]}, 8'd1);
    tick();
    #2 check("nf_stall_mem", {7'd0, st[1]}, 8'd1);
    tick();
    #2 check("nf_release", {7'd0, st[1]}, 8'd0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    #2 check("nf_fwd1", {6'd0, f1[1]}, 8'd0);
    tick();
    idle_n(3);

    // Random streams; a stalled ID instruction is usually held as a real pipeline would.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(exp_stall(i) && $urandom_range(0, 9) < 7)) begin
          bit mdu;
          mdu = ($urandom_range(0, 99) < 8);
          drv(i, $urandom_range(0, 99) < 85, rtag(), rtag(), mdu ? 6'd33 : rtag(),
              !mdu && ($urandom_range(0, 99) < 25), mdu, $urandom_range(0, 99) < 10);
        end
      end
      tick();
    end
    idle_n(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
